shift_sequencer: RTL and testbench

Multi-cycle controller that drives the existing 1-bit `shifter` datapath to shift a 16-bit operand by 0–15 positions. It sits beside the ALU/shifter in the RISC datapath and accepts a start/op/amount request. It latches the operand into an accumulator and loops it through the shifter once per cycle until the count is exhausted. It then presents the result with a one-cycle `done` pulse.

---
 rtl/shift_sequencer_if.sv | 18 +
 rtl/shift_sequencer.sv | 111 +++++++++++
 tb/tb_shift_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Request/result bundle between a datapath controller and the shift sequencer.
// The master issues start/in/op/amount; the slave returns ready/busy/done/out.
interface shift_sequencer_if #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
);
   logic             start;
   logic [WIDTH-1:0] in;
   logic [1:0]       op;
   logic [AMT_W-1:0] amount;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;

   modport master (output start, in, op, amount, input ready, busy, done, out);
   modport slave  (input start, in, op, amount, output ready, busy, done, out);
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller looping an accumulator through the 1-bit shifter.
// Define SHIFT_SEQ_DOUBLE_EN to chain two shifter steps per cycle.
module shifter #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] in,
   input  logic [1:0]       shift,
   output logic [WIDTH-1:0] sout
);
   always_comb begin
      case (shift)
         2'b01:   sout = {in[WIDTH-2:0], 1'b0};
         2'b10:   sout = {1'b0, in[WIDTH-1:1]};
         2'b11:   sout = {in[WIDTH-1], in[WIDTH-1:1]};
         default: sout = in;
      endcase
   end
endmodule

module shift_sequencer #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   shift_sequencer_if.slave   bus
);
`ifdef SHIFT_SEQ_DOUBLE_EN
   localparam int STEPS = 2;
`else
   localparam int STEPS = 1;
`endif

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] acc_reg, acc_next;
   logic [AMT_W-1:0] cnt_reg, cnt_next;
   logic [1:0]       op_q, op_next;

   // chain[0] is the accumulator; chain[n] is the value after n single-bit steps
   logic [WIDTH-1:0] chain [STEPS+1];
   assign chain[0] = acc_reg;

   genvar gi;
   generate
      for (gi = 0; gi < STEPS; gi++) begin : g_step
         shifter #(.WIDTH(WIDTH)) u_shifter (
            .in    (chain[gi]),
            .shift (op_q),
            .sout  (chain[gi+1])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         op_q      <= 2'b00;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
         op_q      <= op_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      op_next    = op_q;
      case (state_reg)
         ST_IDLE: begin
            if (bus.start) begin
               acc_next   = bus.in;
               op_next    = bus.op;
               cnt_next   = bus.amount;
               state_next = (bus.amount != '0) ? ST_SHIFT : ST_DONE;
            end
         end
         ST_SHIFT: begin
`ifdef SHIFT_SEQ_DOUBLE_EN
            if (cnt_reg >= AMT_W'(2)) begin
               acc_next = chain[2];
               cnt_next = cnt_reg - AMT_W'(2);
            end else begin
               acc_next = chain[1];
               cnt_next = cnt_reg - AMT_W'(1);
            end
            if (cnt_next == '0)
               state_next = ST_DONE;
`else
            acc_next = chain[1];
            cnt_next = cnt_reg - AMT_W'(1);
            if (cnt_reg == AMT_W'(1))
               state_next = ST_DONE;
`endif
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   assign bus.ready = (state_reg == ST_IDLE);
   assign bus.busy  = (state_reg == ST_SHIFT) || (state_reg == ST_DONE);
   assign bus.done  = (state_reg == ST_DONE);
   assign bus.out   = acc_reg;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: per-cycle compare against an arithmetic
// model of results and latency, plus literal expectations per request.
module tb_shift_sequencer;
   localparam int WIDTH = 16;
   localparam int AMT_W = 4;

   logic clk = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   done_seen = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) sif ();

   shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (sif.slave)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [15:0] model_result(input logic [15:0] v, input logic [1:0] o, input int n);
      case (o)
         2'b00:   return v;
         2'b01:   return v << n;
         2'b10:   return v >> n;
         default: return 16'($signed(v) >>> n);
      endcase
   endfunction

   function automatic int model_steps(input int n);
`ifdef SHIFT_SEQ_DOUBLE_EN
      return (n + 1) / 2;
`else
      return n;
`endif
   endfunction

   // m_left: -1 when idle, else cycles remaining until the done cycle
   int          m_left = -1;
   logic [15:0] m_out  = '0;

   always @(negedge clk) begin
      if (!reset_n) begin
         m_left = -1;
         m_out  = '0;
      end
      chk("ready", 32'(sif.ready), 32'(m_left < 0));
      chk("busy",  32'(sif.busy),  32'(m_left >= 0));
      chk("done",  32'(sif.done),  32'(m_left == 0));
      if (m_left <= 0)
         chk("out", 32'(sif.out), 32'(m_out));
      if (sif.done)
         done_seen++;
      if (reset_n) begin
         if (m_left == 0)
            m_left = -1;
         else if (m_left > 0)
            m_left--;
         else if (sif.start) begin
            m_left = model_steps(int'(sif.amount));
            m_out  = model_result(sif.in, sif.op, int'(sif.amount));
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!sif.ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!sif.ready)
         chk("ready_timeout", 32'(sif.ready), 32'd1);
   endtask

   task automatic run(input string name, input logic [15:0] v, input logic [1:0] o,
                      input logic [3:0] a, input logic [15:0] lit_out,
                      input int lat_single, input int lat_double, input bit inject);
      int acc_cyc, d0, n, lat, lit_lat;
`ifdef SHIFT_SEQ_DOUBLE_EN
      lit_lat = lat_double;
`else
      lit_lat = lat_single;
`endif
      chk({name, "_model"}, 32'(model_result(v, o, int'(a))), 32'(lit_out));
      wait_ready();
      @(posedge clk); #1;
      sif.start = 1'b1; sif.in = v; sif.op = o; sif.amount = a;
      d0 = done_seen;
      @(posedge clk); #1;
      acc_cyc = cyc;
      sif.start = 1'b0;
      sif.in = 16'($urandom); sif.op = 2'($urandom); sif.amount = 4'($urandom);
      if (inject) begin
         @(posedge clk); #1;
         sif.start = 1'b1; sif.in = 16'h0001; sif.op = 2'b10; sif.amount = 4'd1;
         @(posedge clk); #1;
         sif.start = 1'b0;
      end
      n = 0;
      while (n < 60) begin
         if (sif.done) break;
         @(negedge clk); #1;
         n++;
      end
      chk({name, "_done_timeout"}, 32'(sif.done), 32'd1);
      lat = cyc - acc_cyc + 1;
      chk({name, "_out"}, 32'(sif.out), 32'(lit_out));
      chk({name, "_latency"}, 32'(lat), 32'(lit_lat));
      repeat (3) @(negedge clk);
      #1;
      chk({name, "_done_count"}, 32'(done_seen - d0), 32'd1);
      chk({name, "_out_hold"}, 32'(sif.out), 32'(lit_out));
   endtask

   initial begin
      int d0;
      reset_n = 1'b0;
      sif.start = 1'b0; sif.in = '0; sif.op = '0; sif.amount = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out", 32'(sif.out), 32'h0000);
      reset_n = 1'b1;

      run("left",  16'h0002, 2'b01, 4'd3,  16'h0010, 4,  3, 1'b0);
      run("lsr",   16'h00A0, 2'b10, 4'd5,  16'h0005, 6,  4, 1'b0);
      run("asr",   16'h8000, 2'b11, 4'd4,  16'hF800, 5,  3, 1'b0);
      run("amt0",  16'h1234, 2'b01, 4'd0,  16'h1234, 1,  1, 1'b0);
      run("amt15", 16'hFFFF, 2'b01, 4'd15, 16'h8000, 16, 9, 1'b0);
      run("pass",  16'hBEEF, 2'b00, 4'd6,  16'hBEEF, 7,  4, 1'b0);
      run("busy",  16'h0002, 2'b01, 4'd8,  16'h0200, 9,  5, 1'b1);

      // reset in the middle of a long request
      wait_ready();
      @(posedge clk); #1;
      sif.start = 1'b1; sif.in = 16'h00FF; sif.op = 2'b01; sif.amount = 4'd8;
      @(posedge clk); #1;
      sif.start = 1'b0;
      d0 = done_seen;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rst_out",   32'(sif.out),   32'h0000);
      chk("rst_ready", 32'(sif.ready), 32'd1);
      chk("rst_busy",  32'(sif.busy),  32'd0);
      chk("rst_done",  32'(sif.done),  32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      #1;
      chk("rst_no_done", 32'(done_seen - d0), 32'd0);
      chk("rst_out_after", 32'(sif.out), 32'h0000);

      run("after_rst", 16'h00A0, 2'b11, 4'd2, 16'h0028, 3, 2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
